// File: rtl/cam_stream_rx.sv
// cam_stream_rx: receiver for the 4-bit CAM bus-capture stream.
//
// Oversamples cam_pclk/cam_sync/cam_data in the clk_i domain and reassembles
// MSB-first 8-nibble frames into 32-bit [ADDR:16][DATA:8][FLAGS:8] packets.
// It decodes reset and heartbeat packets, buffers them in a 2-entry FIFO
// behind a valid/ready handshake and keeps wrapping link-health counters.
//
// Ports:
//   clk_i, rst_i            sole clock, synchronous active-high reset
//   cam_pclk/sync/data      asynchronous link inputs (pclk is sampled only)
//   pkt_valid/ready         FIFO head handshake
//   pkt_data + fields       head packet and its combinational decode
//   pkt_count, drop_count,
//   frame_err_count,
//   hb_err_count            16-bit wrapping event counters
//   rx_active               receiver is mid-frame
module cam_stream_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cam_pclk,
  input  logic        cam_sync,
  input  logic [3:0]  cam_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [31:0] pkt_data,
  output logic [15:0] pkt_addr,
  output logic [7:0]  pkt_byte,
  output logic [7:0]  pkt_flags,
  output logic        pkt_is_reset,
  output logic        pkt_is_heartbeat,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count,
  output logic [15:0] frame_err_count,
  output logic [15:0] hb_err_count,
  output logic        rx_active
);

  typedef enum logic [1:0] {StHunt, StIdle, StRecv, StTail} state_e;

  // ---------------------------------------------------------------------------
  // Link synchronizer: the three inputs travel as one bus so they stay aligned.
  // ---------------------------------------------------------------------------
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] link_s;
  logic       pclk_s, sync_s, pclk_d;
  logic [3:0] data_s;
  logic       pclk_evt;
  // Marks when the synchronizer holds real pin samples rather than reset zeros,
  // so HUNT cannot mistake the flushed chain for a low sync.
  logic [SYNC_STAGES:0] fill_q;
  logic                 link_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      pclk_d <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= {cam_pclk, cam_sync, cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      pclk_d <= pclk_s;
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign link_s   = sync_q[SYNC_STAGES-1];
  assign pclk_s   = link_s[5];
  assign sync_s   = link_s[4];
  assign data_s   = link_s[3:0];
  assign pclk_evt = pclk_s & ~pclk_d;
  assign link_ok  = fill_q[SYNC_STAGES];

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [3:0]  nib_cnt_q, nib_cnt_d;
  logic        emit, frame_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StHunt;
      shreg_q   <= '0;
      nib_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    nib_cnt_d = nib_cnt_q;
    emit      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      StHunt: begin
        if (link_ok && !sync_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (pclk_evt && sync_s) begin
          shreg_d   = {28'h0, data_s};
          nib_cnt_d = 4'd1;
          state_d   = StRecv;
        end
      end
      StRecv: begin
        if (pclk_evt && sync_s) begin
          shreg_d   = {shreg_q[27:0], data_s};
          nib_cnt_d = nib_cnt_q + 4'd1;
          if (nib_cnt_q == 4'd7) begin
            emit    = 1'b1;
            state_d = StTail;
          end
        end else if (!sync_s) begin
          // Sync dropped before the 8th nibble: discard the partial frame.
          frame_err = 1'b1;
          nib_cnt_d = 4'd0;
          state_d   = StIdle;
        end
      end
      StTail: begin
        if (pclk_evt && sync_s) begin
          // Overlong frame; the emitted packet stands, resync via HUNT.
          frame_err = 1'b1;
          state_d   = StHunt;
        end else if (!sync_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  assign rx_active = (state_q == StRecv);

  // ---------------------------------------------------------------------------
  // Emit pipeline: the packet is captured at emit and given its own cycle
  // before the FIFO full decision and heartbeat compare.
  // ---------------------------------------------------------------------------
  logic        emit_q, wr_q;
  logic [31:0] emit_data_q, wr_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      emit_q      <= 1'b0;
      emit_data_q <= '0;
      wr_q        <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      emit_q <= emit;
      if (emit) begin
        emit_data_q <= shreg_d;
      end
      wr_q <= emit_q;
      if (emit_q) begin
        wr_data_q <= emit_data_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic        full, pop, do_write, do_drop;

  assign full     = (count_q == 2'd2);
  assign pop      = pkt_valid & pkt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write = wr_q & (~full | pop);
  assign do_drop  = wr_q & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= wr_data_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_write, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pkt_valid        = (count_q != 2'd0);
  assign pkt_data         = mem_q[rd_ptr_q];
  assign pkt_addr         = pkt_data[31:16];
  assign pkt_byte         = pkt_data[15:8];
  assign pkt_flags        = pkt_data[7:0];
  assign pkt_is_reset     = (pkt_data == 32'h0000_0001);
  assign pkt_is_heartbeat = (pkt_addr == 16'hC0FF) && (pkt_flags == 8'hAA);

  // ---------------------------------------------------------------------------
  // Heartbeat sequence check and counters (written packets only)
  // ---------------------------------------------------------------------------
  logic       wr_is_reset, wr_is_hb;
  logic [7:0] wr_byte;
  logic       hb_seen_q;
  logic [7:0] hb_expect_q;

  assign wr_byte     = wr_data_q[15:8];
  assign wr_is_reset = (wr_data_q == 32'h0000_0001);
  assign wr_is_hb    = (wr_data_q[31:16] == 16'hC0FF) && (wr_data_q[7:0] == 8'hAA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hb_seen_q       <= 1'b0;
      hb_expect_q     <= '0;
      pkt_count       <= '0;
      drop_count      <= '0;
      frame_err_count <= '0;
      hb_err_count    <= '0;
    end else begin
      if (do_write) begin
        pkt_count <= pkt_count + 16'd1;
        if (wr_is_reset) begin
          hb_seen_q <= 1'b0;
        end else if (wr_is_hb) begin
          if (hb_seen_q && (wr_byte != hb_expect_q)) begin
            hb_err_count <= hb_err_count + 16'd1;
          end
          hb_seen_q   <= 1'b1;
          hb_expect_q <= wr_byte + 8'd1;
        end
      end
      if (do_drop) begin
        drop_count <= drop_count + 16'd1;
      end
      if (frame_err) begin
        frame_err_count <= frame_err_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/cam_stream_rx.md
# cam_stream_rx

Receiver for the 4-bit CAM bus-capture stream (cam_pclk/cam_sync/cam_data). It oversamples the link in its own clock domain, reassembles 32-bit `[ADDR:16][DATA:8][FLAGS:8]` packets and decodes the reset and heartbeat packets. It buffers the packets in a 2-entry FIFO behind a valid/ready handshake and keeps link-health counters. It is used for on-board loopback of the capture stream and as the receive end on a second FPGA.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for the three link inputs (≥2).
- `clk_i` in 1: sole clock. It must be ≥4× the cam_pclk frequency.
- `rst_i` in 1: reset, synchronous, active-high.
- `cam_pclk` in 1: link clock, asynchronous. It is sampled, never used as a clock.
- `cam_sync` in 1: frame strobe. High for exactly the 8 nibbles of one packet.
- `cam_data` in 4: nibble, MSB-first. Valid at the cam_pclk rising edge.
- `pkt_valid` out 1: FIFO head is valid.
- `pkt_ready` in 1: consumer accepts the head when `pkt_valid & pkt_ready`.
- `pkt_data` out 32: raw packet.
- `pkt_addr` out 16, `pkt_byte` out 8, `pkt_flags` out 8: fields of `pkt_data`, taken from [31:16], [15:8] and [7:0].
- `pkt_is_reset` out 1: `pkt_data == 32'h0000_0001`.
- `pkt_is_heartbeat` out 1: `pkt_addr == 16'hC0FF && pkt_flags == 8'hAA`.
- `pkt_count` out 16: packets written into the FIFO. Wraps.
- `drop_count` out 16: packets discarded because the FIFO was full. Wraps.
- `frame_err_count` out 16: framing errors. Wraps.
- `hb_err_count` out 16: heartbeat sequence errors. Wraps.
- `rx_active` out 1: FSM is in RECV.

## Operation
- The three link inputs pass through `SYNC_STAGES` flops as one aligned bus, then one more register (`*_d`).
- A pclk event is `pclk_s & !pclk_d`. On an event, the receiver uses `sync_s` and `data_s`.
- FSM states:
  - HUNT (reset state): wait for `sync_s == 0`, then go to IDLE. This prevents locking onto a packet that is already in progress.
  - IDLE: on an event with sync=1, shift the nibble in, set nib_cnt=1 and go to RECV. An event with sync=0 is ignored.
  - RECV: on an event with sync=1, shift left 4 and insert the nibble at [3:0], then nib_cnt++. When the 8th nibble lands, emit the packet and go to TAIL.
  - RECV: if `sync_s` falls with nib_cnt<8, increment frame_err_count, discard the partial packet and go to IDLE.
  - TAIL: wait for `sync_s == 0`, then go to IDLE. An event with sync=1 in TAIL (a 9th nibble) increments frame_err_count and goes to HUNT. The already-emitted packet stands.
- Emit rules:
  - FIFO not full: write the packet and increment pkt_count.
  - FIFO full: discard the new packet (head and order preserved) and increment drop_count.
  - FIFO full with a pop in the same cycle: this is not full. Write and pop both occur.
- Heartbeat check runs at emit time, on the written packet:
  - A reset packet clears `hb_seen`.
  - A heartbeat with `hb_seen=0` loads `hb_expect = byte+1` and sets `hb_seen`.
  - A heartbeat with `hb_seen=1` and `byte != hb_expect` increments hb_err_count.
  - Either way, `hb_expect` then becomes `byte+1`, mod 256, so 8'hFF→8'h00 is legal.
  - Dropped packets are not checked.
- Decode outputs (`pkt_addr`, `pkt_byte`, `pkt_flags`, `pkt_is_reset`, `pkt_is_heartbeat`) are combinational from the FIFO head. `pkt_data` etc. are don't-care when `pkt_valid=0`.

## Timing
- Reset: on `rst_i` high at a clk_i edge, all of the following are 0 and the FSM is in HUNT: outputs, counters, FIFO, sync flops, `hb_seen`, `hb_expect`.
- Reset mid-packet: the partial packet is lost. Resumption happens only via HUNT after sync goes low.
- Latency: for an 8th-nibble pclk edge at the pin, `pkt_valid` rises by `SYNC_STAGES+3` clk_i cycles (5 with default SYNC_STAGES=2), when the FIFO was empty.
- Throughput: one packet per frame. Back-to-back frames require sync low for ≥2 clk_i cycles between frames.
- Link constraints: pclk high and low time ≥2 clk_i cycles each. Data and sync must be stable ≥2 clk_i cycles around the pclk rising edge.
- Handshake: `pkt_valid` stays high and the head is stable until accepted. The head advances on the accept cycle. A FIFO write that lands when the FIFO is empty is visible on the next cycle, never the same cycle.
- Counters update one cycle after the event that causes them.

## Test plan
- Single frame with nibbles 1,2,3,4,5,6,7,8 and `pkt_ready=1`:
  - `pkt_data=32'h12345678`, `pkt_addr=16'h1234`, `pkt_byte=8'h56`, `pkt_flags=8'h78`.
  - `pkt_valid` asserts 5 cycles after the 8th edge. `pkt_count=1`.
- Reset packet `32'h00000001`, then heartbeats with bytes 8'hFE, 8'hFF, 8'h00, 8'h02 (flags 8'hAA, addr 16'hC0FF):
  - `pkt_is_reset=1` for the first packet and `pkt_is_heartbeat=1` for each heartbeat.
  - `hb_err_count=1`, caused only by 8'h02.
- `pkt_ready=0`, send 3 frames A, B, C:
  - `drop_count=1` and `pkt_count=2`.
  - On release, A is popped, then B. C never appears.
- Sync falls after 5 nibbles, then a good frame `32'hC0308D80` follows: `frame_err_count=1`, and only `32'hC0308D80` is delivered.
- Frame with 9 nibbles under one sync:
  - The first 8 nibbles are delivered.
  - `frame_err_count=1`.
  - The next valid frame is received only after sync has gone low.
- Start with `cam_sync` held high across reset release, with 4 nibbles arriving mid-frame:
  - No packet and no frame error result; the FSM stays in HUNT.
  - The next full frame is delivered correctly.
- Assert `rst_i` in RECV after 3 nibbles: all counters read 0 and `pkt_valid=0` on the next cycle.
